uart_rx: RTL
============

Name: uart_rx

Overview:
UART receiver, the receive-side counterpart of the UART transmitter in the same controller. It deserialises frames from the serial line and presents each word with a one-cycle valid strobe and a frame-error flag. Frame format comes from the shared 12-bit control word (ctrl_reg_t from data_types_pkg: br_div, word, stop), so RX and TX agree on format. Data bits arrive MSB first, matching the transmitter.

Parameters:
SYNC_STAGES, 2, number of flops in the rx_in metastability synchroniser (minimum 2)
MIN_DIV, 4, smallest effective bit period in clk cycles; a br_div value below this is treated as MIN_DIV

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
control  input  12  ctrl_reg_t: br_div = bit period in clk cycles; word 1 = 9 data bits, 0 = 8; stop 1 = 2 stop bits, 0 = 1
rx_in  input  1  serial line, idle high, asynchronous to clk
data  output  9  received word, right-aligned; data[8] = 0 in 8-bit mode
valid  output  1  one-cycle pulse; data and frame_err are valid on this cycle
frame_err  output  1  set with valid when any sampled stop bit is 0
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset: state = IDLE; data = 0, valid = 0, frame_err = 0, busy = 0; synchroniser flops = 1; reset abandons any frame in progress with no valid pulse.
- rx_s = rx_in after SYNC_STAGES flops. All timing below is relative to rx_s.
- Internal counters: bit-period counter (width of br_div); bit index (4 bits); stop index (1 bit). P = max(br_div, MIN_DIV); H = P >> 1.
- Control is latched on the cycle the start edge is detected. A change to control mid-frame does not affect the current frame.
- IDLE: an armed receiver that sees rx_s go 1 -> 0 enters START and loads counter = H.
- START: count down. At 0, sample rx_s:
  - If 1: false start (glitch). Return to IDLE with no valid.
  - If 0: enter DATA, load counter = P, set bit index = 8 (word = 1) or 7 (word = 0).
- DATA: at each counter expiry, sample rx_s into shift[bit index]. This is MSB first; the first sampled bit lands at the highest index.
  - If bit index = 0, enter STOP and reload P.
  - Otherwise decrement bit index and reload P.
  - For 8-bit words, shift[8] is forced to 0.
- STOP: at each expiry, sample rx_s; any 0 sets the internal err flag.
  - If stop = 1 and this is the first stop bit, reload P and stay in STOP.
  - Otherwise drive valid = 1 for exactly one cycle, with data = shift and frame_err = err, then enter IDLE.
- Outputs are registered. data holds its value until the next valid; frame_err is meaningful only while valid = 1.
- Sampling point: mid-bit (H cycles after the start edge, then every P cycles). Tolerates about ±40% of a bit period of cumulative edge skew.
- Back-to-back frames: valid and the return to IDLE happen at mid-stop, so a transmitter going STOP -> START directly is received with no lost frame.
- Re-arm rule: after a frame with frame_err = 1 (break or held-low line), IDLE is not armed until rx_s has been 1 for at least one cycle. A line held low is therefore never read as repeated start bits. After reset, IDLE is armed.
- Latency: valid rises 1 cycle after the final stop-bit sample, i.e. (1 + N + S - 0.5)·P + 1 + SYNC_STAGES cycles after the rx_in falling edge. Here N = data bits and S = stop bits; tolerance is ±1 cycle for edge alignment.
- No receive FIFO: the consumer must take data on valid. Overrun is the consumer's problem.

Test Plan:
- br_div = 16, word = 0, stop = 0; send 0xA5 MSB first -> exactly one valid pulse, data = 0x0A5, frame_err = 0, busy low afterwards; valid timing within ±1 cycle of the latency formula.
- br_div = 20, word = 1, stop = 1; send 0x1C3 with 2 stop bits -> data = 0x1C3, frame_err = 0. Repeat with the second stop bit driven 0 -> data = 0x1C3, frame_err = 1.
- Glitch: rx_in low for 3 cycles at br_div = 16 -> no valid, state back to IDLE, busy low within H + SYNC_STAGES + 2 cycles.
- Break: rx_in held low for 30 bit periods -> one valid with data = 0x000 and frame_err = 1, then no further valid until rx_in returns high. A following 0x3C frame is received correctly.
- Loopback with uart_tx (br_div = 16, word = 0, stop = 0): back-to-back 0x55, 0xAA, 0xFF with start held high -> three valid pulses in order, all frame_err = 0.
- Reset asserted mid-DATA of 0x81 -> all outputs 0 on the next cycle, no valid. A subsequent 0x42 frame is received as data = 0x042.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: synchronises rx_in, detects start edges, samples each bit at mid-period
// (MSB first) and emits the received word with a one-cycle valid strobe and frame-error flag.
module uart_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_DIV     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [11:0] control,
  input  logic       rx_in,
  output logic [8:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int DW = 10;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // control layout matches ctrl_reg_t: {br_div[9:0], word, stop}
  logic [DW-1:0] br_div;
  logic [DW-1:0] p_ctl;
  logic [DW-1:0] h_ctl;
  logic          rx_s;
  logic          expire;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic          rx_prev_q, rx_prev_d;
  logic          armed_q, armed_d;
  state_t        state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_idx_q, bit_idx_d;
  logic          stop_idx_q, stop_idx_d;
  logic [DW-1:0] p_q, p_d;
  logic          word_q, word_d;
  logic          stop_q, stop_d;
  logic [8:0]    shift_q, shift_d;
  logic          err_q, err_d;
  logic [8:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          frame_err_q, frame_err_d;

  assign br_div = control[11:2];
  assign p_ctl  = (br_div < DW'(MIN_DIV)) ? DW'(MIN_DIV) : br_div;
  assign h_ctl  = p_ctl >> 1;
  assign rx_s   = sync_q[SYNC_STAGES-1];
  assign expire = (cnt_q == '0);

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], rx_in};
    rx_prev_d   = rx_s;
    armed_d     = armed_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    stop_idx_d  = stop_idx_q;
    p_d         = p_q;
    word_d      = word_q;
    stop_d      = stop_q;
    shift_d     = shift_q;
    err_d       = err_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frame_err_d = frame_err_q;

    // Counters are loaded with N-1 so that each expiry lands exactly N cycles later.
    unique case (state_q)
      IDLE: begin
        if (rx_s) armed_d = 1'b1;
        if (armed_q && rx_prev_q && !rx_s) begin
          state_d    = START;
          cnt_d      = h_ctl - DW'(1);
          p_d        = p_ctl;
          word_d     = control[1];
          stop_d     = control[0];
          err_d      = 1'b0;
          stop_idx_d = 1'b0;
          shift_d    = '0;
        end
      end
      START: begin
        if (!expire) begin
          cnt_d = cnt_q - DW'(1);
        end else if (rx_s) begin
          state_d = IDLE;
        end else begin
          state_d   = DATA;
          cnt_d     = p_q - DW'(1);
          bit_idx_d = word_q ? 4'd8 : 4'd7;
        end
      end
      DATA: begin
        if (!expire) begin
          cnt_d = cnt_q - DW'(1);
        end else begin
          shift_d[bit_idx_q] = rx_s;
          if (!word_q) shift_d[8] = 1'b0;
          cnt_d = p_q - DW'(1);
          if (bit_idx_q == 4'd0) state_d = STOP;
          else bit_idx_d = bit_idx_q - 4'd1;
        end
      end
      STOP: begin
        if (!expire) begin
          cnt_d = cnt_q - DW'(1);
        end else if (stop_q && !stop_idx_q) begin
          if (!rx_s) err_d = 1'b1;
          stop_idx_d = 1'b1;
          cnt_d      = p_q - DW'(1);
        end else begin
          // Finish at mid-stop so a directly following start edge is not missed;
          // a bad frame disarms IDLE until the line has been seen high again.
          err_d       = err_q | !rx_s;
          valid_d     = 1'b1;
          data_d      = shift_q;
          frame_err_d = err_q | !rx_s;
          armed_d     = !(err_q | !rx_s);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= '1;
      rx_prev_q   <= 1'b1;
      armed_q     <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      stop_idx_q  <= 1'b0;
      p_q         <= '0;
      word_q      <= 1'b0;
      stop_q      <= 1'b0;
      shift_q     <= '0;
      err_q       <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      rx_prev_q   <= rx_prev_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      stop_idx_q  <= stop_idx_d;
      p_q         <= p_d;
      word_q      <= word_d;
      stop_q      <= stop_d;
      shift_q     <= shift_d;
      err_q       <= err_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

endmodule
